// File: rtl/uart_tx_char_fifo.sv
// uart_tx_char_fifo
//   First-word-fall-through character FIFO feeding the UART transmit controller.
//   The upstream formatter pushes bytes. The tx controller reads dout while empty is low
//   and pops with a single-cycle rd_en.
//   Ports:
//     clk_tx, rst_clk_tx_n     clock, asynchronous active-low reset
//     wr_en, din               push interface
//     full, almost_full        write-side status
//     rd_en, dout, empty       pop interface (dout is the head, 8'h00 when empty)
//     level                    occupancy 0..DEPTH
//     clr_err                  clears the sticky flags
//     overflow, underflow      sticky debug flags
module uart_tx_char_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12
) (
    input  logic              clk_tx,
    input  logic              rst_clk_tx_n,
    input  logic              wr_en,
    input  logic [7:0]        din,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [7:0]        dout,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LVL);

    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    // Status is decoded straight from the registered pointers. Every flag therefore
    // settles right after each edge, and it also follows the asynchronous reset immediately.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                         (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign level       = wr_ptr - rd_ptr;
    assign almost_full = (level >= AF_THR);

    // A pop in the same cycle frees a slot, so a write into a full FIFO still goes through.
    // A pop from an empty FIFO is ignored, even when a write arrives in the same cycle.
    assign push_ok = wr_en && (!full || rd_en);
    assign pop_ok  = rd_en && !empty;

    assign dout = empty ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];

    // The storage array is not reset. Stale entries can never be observed,
    // because dout is masked while the FIFO is empty.
    always_ff @(posedge clk_tx) begin
        if (push_ok)
            mem[wr_ptr[ADDR_W-1:0]] <= din;
    end

    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            // A set event in the same cycle as clr_err takes priority over the clear.
            overflow  <= (overflow  && !clr_err) || (wr_en && !push_ok);
            underflow <= (underflow && !clr_err) || (rd_en && empty);
        end
    end

endmodule

// File: tb/tb_uart_tx_char_fifo.sv
// Testbench for uart_tx_char_fifo.
// Directed scenarios plus random traffic are compared against a queue-based reference model.
module tb_uart_tx_char_fifo;

    logic       clk_tx = 1'b0;
    logic       rst_clk_tx_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic       full, almost_full, empty, overflow, underflow;
    logic [7:0] dout;
    logic [4:0] level;

    int errs = 0;
    int checks = 0;

    // Reference model: a plain queue of bytes plus two sticky bits.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    uart_tx_char_fifo #(.DEPTH(16), .ADDR_W(4), .AF_LVL(12)) dut (
        .clk_tx       (clk_tx),
        .rst_clk_tx_n (rst_clk_tx_n),
        .wr_en        (wr_en),
        .din          (din),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .dout         (dout),
        .empty        (empty),
        .level        (level),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk_tx = ~clk_tx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n = q.size();
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == 16));
        chk({tag, ".af"}, 32'(almost_full), 32'(n >= 12));
        chk({tag, ".level"}, 32'(level), 32'(n));
        chk({tag, ".dout"}, 32'(dout), (n == 0) ? 32'h0 : 32'(q[0]));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    // Model of one clock edge, written directly from the accept rules.
    task automatic model_edge(input logic w, input logic [7:0] d, input logic r, input logic c);
        int  n = q.size();
        logic pu = w && (n < 16 || r);
        logic po = r && (n > 0);
        if (po) void'(q.pop_front());
        if (pu) q.push_back(d);
        m_ovf = (m_ovf && !c) || (w && !pu);
        m_unf = (m_unf && !c) || (r && n == 0);
    endtask

    task automatic step(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        wr_en = w; din = d; rd_en = r; clr_err = c;
        @(posedge clk_tx);
        model_edge(w, d, r, c);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        #2 rst_clk_tx_n = 1'b0;
        #1;
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        check_all("rst_async");
        @(negedge clk_tx);
        check_all("rst_hold");
        @(negedge clk_tx);
        rst_clk_tx_n = 1'b1;
    endtask

    initial begin
        // T1 reset
        do_reset();
        @(posedge clk_tx); #1;
        check_all("t1_post");

        // T2 FWFT
        step("t2_wr", 1, 8'h41, 0, 0);
        step("t2_rd", 0, 8'h00, 1, 0);

        // T3 fill, overflow, ordered readout
        for (int i = 0; i < 16; i++) step("t3_fill", 1, 8'(i), 0, 0);
        step("t3_ovf", 1, 8'hFF, 0, 0);
        for (int i = 0; i < 4; i++) step("t3_rd", 0, 8'h00, 1, 0);
        step("t3_clr", 0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) step("t3_refill", 1, 8'(8'h10 + i), 0, 0);

        // T4 simultaneous read+write while full
        step("t4_rw_full", 1, 8'hAA, 1, 0);
        for (int i = 0; i < 16; i++) step("t4_drain", 0, 8'h00, 1, 0);

        // T5 underflow, empty read+write, clear
        step("t5_unf", 0, 8'h00, 1, 0);
        step("t5_rw_empty", 1, 8'h55, 1, 0);
        step("t5_clr", 0, 8'h00, 0, 1);
        step("t5_clr_win", 0, 8'h00, 1, 1);
        step("t5_drain", 0, 8'h00, 1, 1);

        // T6 random interleaved traffic with gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                step("t6_gap", 0, 8'h00, 0, 0);
            else
                step("t6_rnd", 1'($urandom_range(0, 1)), 8'($urandom),
                     1'($urandom_range(0, 1)), 0);
        end
        // Broader random phase that pushes toward full so it wraps and overflows.
        for (int i = 0; i < 300; i++)
            step("t6_wide", 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));

        // Reset in the middle of operation with level 5
        while (q.size() > 0) step("t6_flush", 0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) step("t6_pre", 1, 8'(8'h30 + i), 0, 0);
        chk("t6_level5", 32'(level), 32'd5);
        do_reset();
        step("t6_post_wr", 1, 8'h7E, 0, 0);
        chk("t6_dout7e", 32'(dout), 32'h7E);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
